myo_frame_scheduler: RTL and testbench

MYO_FRAME_SCHEDULER -- requirements
Module: myo_frame_scheduler

---
 rtl/myo_pkg.sv | 38 +++
 rtl/myo_feedback_bank.sv | 56 +++++
 rtl/myo_frame_scheduler.sv | 180 ++++++++++++++++++
 tb/tb_myo_frame_scheduler.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/myo_pkg.sv
// Shared types for the myo frame scheduler: FSM states, readback field codes
// and the per-motor feedback record.
package myo_pkg;

    localparam int unsigned MAX_MOTORS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT_ACK,
        WAIT_DONE,
        LATCH,
        NEXT
    } state_e;

    typedef enum logic [2:0] {
        FIELD_POSITION     = 3'd0,
        FIELD_VELOCITY     = 3'd1,
        FIELD_CURRENT      = 3'd2,
        FIELD_DISPLACEMENT = 3'd3,
        FIELD_SENSOR1      = 3'd4,
        FIELD_SENSOR2      = 3'd5
    } field_e;

    typedef struct packed {
        logic signed [31:0] position;
        logic signed [15:0] velocity;
        logic signed [15:0] current;
        logic signed [15:0] displacement;
        logic signed [15:0] sensor1;
        logic signed [15:0] sensor2;
    } feedback_t;

    function automatic logic [31:0] sext16(input logic [15:0] value);
        return {{16{value[15]}}, value};
    endfunction

endpackage

// File: rtl/myo_feedback_bank.sv
// Per-motor feedback storage: one write port fed from the LATCH state and a
// registered readback mux addressed by motor and field.
module myo_feedback_bank
    import myo_pkg::*;
#(
    parameter int NUMBER_OF_MOTORS = 6
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        write_en,
    input  logic [2:0]  write_motor,
    input  feedback_t   write_data,
    input  logic [2:0]  read_motor,
    input  logic [2:0]  read_field,
    output logic [31:0] read_data
);

    feedback_t   bank [MAX_MOTORS];
    feedback_t   selected;
    logic [31:0] read_next;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < MAX_MOTORS; i++) begin
                bank[i] <= '0;
            end
        end else if (write_en) begin
            bank[write_motor] <= write_data;
        end
    end

    always_comb begin
        selected  = bank[read_motor];
        read_next = '0;
        if (int'(read_motor) < NUMBER_OF_MOTORS) begin
            case (read_field)
                FIELD_POSITION:     read_next = selected.position;
                FIELD_VELOCITY:     read_next = sext16(selected.velocity);
                FIELD_CURRENT:      read_next = sext16(selected.current);
                FIELD_DISPLACEMENT: read_next = sext16(selected.displacement);
                FIELD_SENSOR1:      read_next = sext16(selected.sensor1);
                FIELD_SENSOR2:      read_next = sext16(selected.sensor2);
                default:            read_next = '0;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            read_data <= '0;
        end else begin
            read_data <= read_next;
        end
    end

endmodule

// File: rtl/myo_frame_scheduler.sv
// Periodic sweep scheduler: on each period tick it requests one SPI frame per
// motor, supervises the handshake with a per-frame timeout and banks feedback.
module myo_frame_scheduler
    import myo_pkg::*;
#(
    parameter int NUMBER_OF_MOTORS = 6,
    parameter int UPDATE_PERIOD    = 500000,
    parameter int TIMEOUT_CYCLES   = 4096
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               enable,
    input  logic               pwm_write,
    input  logic [2:0]         pwm_address,
    input  logic signed [31:0] pwm_writedata,
    input  logic               spi_done,
    input  logic signed [31:0] position,
    input  logic signed [15:0] velocity,
    input  logic signed [15:0] current,
    input  logic signed [15:0] displacement,
    input  logic signed [15:0] sensor1,
    input  logic signed [15:0] sensor2,
    output logic               start,
    output logic signed [31:0] pwmRef,
    output logic [2:0]         motor_select,
    input  logic [2:0]         read_motor,
    input  logic [2:0]         read_field,
    output logic [31:0]        read_data,
    output logic [7:0]         timeout_flags,
    output logic               overrun
);

    localparam int PERIOD_W = (UPDATE_PERIOD > 1) ? $clog2(UPDATE_PERIOD) : 1;
    localparam int TIMER_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [PERIOD_W-1:0] PERIOD_LAST = PERIOD_W'(UPDATE_PERIOD - 1);
    localparam logic [TIMER_W-1:0]  TIMER_LAST  = TIMER_W'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0]          LAST_MOTOR  = 3'(NUMBER_OF_MOTORS - 1);

    logic [PERIOD_W-1:0] period_count;
    logic                tick;
    logic signed [31:0]  shadow [MAX_MOTORS];
    state_e              state;
    logic [TIMER_W-1:0]  timer;
    logic                timed_out;
    logic [2:0]          next_motor;
    feedback_t           feedback;

    // Free-running: the sweep cadence never depends on enable or FSM state.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            period_count <= '0;
            tick         <= 1'b0;
        end else if (period_count == PERIOD_LAST) begin
            period_count <= '0;
            tick         <= 1'b1;
        end else begin
            period_count <= period_count + PERIOD_W'(1);
            tick         <= 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < MAX_MOTORS; i++) begin
                shadow[i] <= '0;
            end
        end else if (pwm_write && (int'(pwm_address) < NUMBER_OF_MOTORS)) begin
            shadow[pwm_address] <= pwm_writedata;
        end
    end

    assign timed_out  = (timer == TIMER_LAST);
    assign next_motor = motor_select + 3'd1;

    // The timer restarts on every START entry and is checked ahead of the
    // handshake in all three frame states, so a stuck engine always ends in NEXT.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            start         <= 1'b0;
            pwmRef        <= '0;
            motor_select  <= '0;
            timer         <= '0;
            timeout_flags <= '0;
            overrun       <= 1'b0;
        end else begin
            if (tick && (state != IDLE)) begin
                overrun <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (tick && enable) begin
                        motor_select <= '0;
                        pwmRef       <= shadow[0];
                        timer        <= '0;
                        state        <= START;
                    end
                end
                START: begin
                    if (timed_out) begin
                        start                       <= 1'b0;
                        timeout_flags[motor_select] <= 1'b1;
                        state                       <= NEXT;
                    end else begin
                        timer <= timer + TIMER_W'(1);
                        if (spi_done) begin
                            start <= 1'b1;
                            state <= WAIT_ACK;
                        end
                    end
                end
                WAIT_ACK: begin
                    if (timed_out) begin
                        start                       <= 1'b0;
                        timeout_flags[motor_select] <= 1'b1;
                        state                       <= NEXT;
                    end else begin
                        timer <= timer + TIMER_W'(1);
                        if (!spi_done) begin
                            start <= 1'b0;
                            state <= WAIT_DONE;
                        end
                    end
                end
                WAIT_DONE: begin
                    if (timed_out) begin
                        start                       <= 1'b0;
                        timeout_flags[motor_select] <= 1'b1;
                        state                       <= NEXT;
                    end else begin
                        timer <= timer + TIMER_W'(1);
                        if (spi_done) begin
                            state <= LATCH;
                        end
                    end
                end
                LATCH: begin
                    state <= NEXT;
                end
                NEXT: begin
                    if (motor_select == LAST_MOTOR) begin
                        state <= IDLE;
                    end else begin
                        motor_select <= next_motor;
                        pwmRef       <= shadow[next_motor];
                        timer        <= '0;
                        state        <= START;
                    end
                end
                default: begin
                    start <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        feedback.position     = position;
        feedback.velocity     = velocity;
        feedback.current      = current;
        feedback.displacement = displacement;
        feedback.sensor1      = sensor1;
        feedback.sensor2      = sensor2;
    end

    myo_feedback_bank #(
        .NUMBER_OF_MOTORS(NUMBER_OF_MOTORS)
    ) u_bank (
        .clock      (clock),
        .reset_n    (reset_n),
        .write_en   (state == LATCH),
        .write_motor(motor_select),
        .write_data (feedback),
        .read_motor (read_motor),
        .read_field (read_field),
        .read_data  (read_data)
    );

endmodule

// File: tb/tb_myo_frame_scheduler.sv
// Directed bench for myo_frame_scheduler with a behavioural SPI frame-engine
// model; expected values are hand-derived constants and cycle offsets.
module tb_myo_frame_scheduler;

    logic               clock;
    logic               reset_n;
    logic               enable;
    logic               pwm_write;
    logic [2:0]         pwm_address;
    logic signed [31:0] pwm_writedata;
    logic               spi_done;
    logic signed [31:0] position;
    logic signed [15:0] velocity, current, displacement, sensor1, sensor2;
    logic               start;
    logic signed [31:0] pwmRef;
    logic [2:0]         motor_select;
    logic [2:0]         read_motor, read_field;
    logic [31:0]        read_data;
    logic [7:0]         timeout_flags;
    logic               overrun;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;
    int rel_cyc      = 0;

    // Engine model state
    bit                 hang0     = 1'b0;
    int                 frame_len = 200;
    bit                 busy;
    int                 busy_cnt;
    logic signed [31:0] eng_pos;
    logic signed [15:0] eng_vel, eng_cur, eng_disp, eng_s1, eng_s2;

    // Frame log
    int         nframes = 0;
    int         f_t [32];
    logic [2:0] f_ms [32];
    logic [31:0] f_pwm [32];
    int         f_w [32];
    logic       start_q = 1'b0;

    myo_frame_scheduler #(
        .NUMBER_OF_MOTORS(2),
        .UPDATE_PERIOD   (1000),
        .TIMEOUT_CYCLES  (4096)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .enable       (enable),
        .pwm_write    (pwm_write),
        .pwm_address  (pwm_address),
        .pwm_writedata(pwm_writedata),
        .spi_done     (spi_done),
        .position     (position),
        .velocity     (velocity),
        .current      (current),
        .displacement (displacement),
        .sensor1      (sensor1),
        .sensor2      (sensor2),
        .start        (start),
        .pwmRef       (pwmRef),
        .motor_select (motor_select),
        .read_motor   (read_motor),
        .read_field   (read_field),
        .read_data    (read_data),
        .timeout_flags(timeout_flags),
        .overrun      (overrun)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Engine: accepts a request one cycle after start, busy for frame_len cycles.
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            spi_done <= 1'b1;
            busy     <= 1'b0;
            busy_cnt <= 0;
            eng_pos  <= '0;
            eng_vel  <= '0;
            eng_cur  <= '0;
            eng_disp <= '0;
            eng_s1   <= '0;
            eng_s2   <= '0;
        end else if (busy) begin
            if (busy_cnt <= 1) begin
                spi_done <= 1'b1;
                busy     <= 1'b0;
            end else begin
                busy_cnt <= busy_cnt - 1;
            end
        end else if (start && spi_done && !(hang0 && motor_select == 3'd0)) begin
            spi_done <= 1'b0;
            busy     <= 1'b1;
            busy_cnt <= frame_len;
            if (motor_select == 3'd0) begin
                eng_pos <= 32'h0000_0AAA; eng_vel <= 16'sd7;     eng_cur <= 16'h1234;
                eng_disp <= 16'hFF00;     eng_s1  <= 16'h8001;   eng_s2  <= 16'h0042;
            end else begin
                eng_pos <= 32'h0001_2345; eng_vel <= -16'sd3;    eng_cur <= 16'h0010;
                eng_disp <= 16'h0020;     eng_s1  <= 16'h7FFF;   eng_s2  <= 16'hFFFE;
            end
        end
    end

    // A hung motor 0 presents junk feedback that must never reach the bank.
    assign position     = (hang0 && motor_select == 3'd0) ? 32'hDEAD_BEEF : eng_pos;
    assign velocity     = (hang0 && motor_select == 3'd0) ? 16'hBEEF : eng_vel;
    assign current      = eng_cur;
    assign displacement = eng_disp;
    assign sensor1      = eng_s1;
    assign sensor2      = eng_s2;

    always @(negedge clock) begin
        if (start && !start_q) begin
            if (nframes < 32) begin
                f_t[nframes]   = cyc;
                f_ms[nframes]  = motor_select;
                f_pwm[nframes] = pwmRef;
                f_w[nframes]   = 0;
            end
            nframes = nframes + 1;
        end
        if (start && nframes > 0 && nframes <= 32) f_w[nframes-1] = f_w[nframes-1] + 1;
        start_q = start;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic wait_frames(input int n, input int budget);
        int left;
        left = budget;
        while (nframes < n && left > 0) begin
            @(negedge clock);
            left--;
        end
        #1;
        check($sformatf("wait_frame_%0d", n), 32'(nframes >= n), 32'd1);
    endtask

    task automatic read_check(input string tag, input logic [2:0] m, input logic [2:0] f,
                              input logic [31:0] exp);
        read_motor = m;
        read_field = f;
        @(negedge clock);
        check(tag, read_data, exp);
    endtask

    task automatic shadow_write(input logic [2:0] a, input logic [31:0] d);
        pwm_write     = 1'b1;
        pwm_address   = a;
        pwm_writedata = d;
        @(negedge clock);
        pwm_write     = 1'b0;
    endtask

    initial begin
        reset_n       = 1'b0;
        enable        = 1'b0;
        pwm_write     = 1'b0;
        pwm_address   = '0;
        pwm_writedata = '0;
        read_motor    = '0;
        read_field    = '0;
        repeat (3) @(negedge clock);
        #1;
        check("rst_start",    32'(start), 32'd0);
        check("rst_pwmref",   pwmRef, 32'd0);
        check("rst_msel",     32'(motor_select), 32'd0);
        check("rst_readdata", read_data, 32'd0);
        check("rst_tflags",   32'(timeout_flags), 32'd0);
        check("rst_overrun",  32'(overrun), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        rel_cyc = cyc;

        shadow_write(3'd0, 32'd100);
        shadow_write(3'd1, -32'sd5);
        enable = 1'b1;

        // First sweep: tick after a full period, START one cycle later, start the next.
        wait_frames(1, 1500);
        check("first_start_delay", 32'(f_t[0] - rel_cyc), 32'd1002);
        shadow_write(3'd0, 32'd7);
        shadow_write(3'd6, 32'd55);
        repeat (50) @(negedge clock);
        check("pwm_hold_active", pwmRef, 32'd100);
        check("msel_hold_active", 32'(motor_select), 32'd0);

        wait_frames(2, 600);
        check("f0_pwm",   f_pwm[0], 32'd100);
        check("f0_msel",  32'(f_ms[0]), 32'd0);
        check("f0_width", 32'(f_w[0]), 32'd2);
        check("f1_pwm",   f_pwm[1], 32'hFFFF_FFFB);
        check("f1_msel",  32'(f_ms[1]), 32'd1);
        repeat (300) @(negedge clock);
        check("f1_width", 32'(f_w[1]), 32'd2);

        read_check("rd_m1_pos",   3'd1, 3'd0, 32'h0001_2345);
        read_check("rd_m1_vel",   3'd1, 3'd1, 32'hFFFF_FFFD);
        read_check("rd_m1_s1",    3'd1, 3'd4, 32'h0000_7FFF);
        read_check("rd_m1_s2",    3'd1, 3'd5, 32'hFFFF_FFFE);
        read_check("rd_m0_cur",   3'd0, 3'd2, 32'h0000_1234);
        read_check("rd_m0_disp",  3'd0, 3'd3, 32'hFFFF_FF00);
        read_check("rd_m0_s1",    3'd0, 3'd4, 32'hFFFF_8001);
        read_check("rd_bad_fld",  3'd0, 3'd6, 32'd0);
        read_check("rd_bad_mot",  3'd2, 3'd0, 32'd0);
        check("no_overrun", 32'(overrun), 32'd0);
        check("no_timeout", 32'(timeout_flags), 32'd0);

        // Second sweep picks up the shadow value written during frame 0.
        wait_frames(3, 1500);
        check("f2_pwm",    f_pwm[2], 32'd7);
        check("f2_period", 32'(f_t[2] - f_t[0]), 32'd1000);
        wait_frames(4, 600);
        repeat (300) @(negedge clock);

        // Long frames: a tick lands mid-sweep and the next sweep waits one more period.
        frame_len = 600;
        wait_frames(6, 2500);
        check("f5_msel",  32'(f_ms[5]), 32'd1);
        check("f5_width", 32'(f_w[5]), 32'd2);
        frame_len = 200;
        hang0     = 1'b1;
        wait_frames(7, 2000);
        check("overrun_set",   32'(overrun), 32'd1);
        check("overrun_delay", 32'(f_t[6] - f_t[4]), 32'd2000);
        check("f6_msel",       32'(f_ms[6]), 32'd0);

        // Motor 0 hangs: timeout after 4096 cycles in the frame, motor 1 still served.
        wait_frames(8, 5000);
        repeat (300) @(negedge clock);
        check("timeout_flags", 32'(timeout_flags), 32'h01);
        check("timeout_gap",   32'(f_t[7] - f_t[6]), 32'd4097);
        check("timeout_width", 32'(f_w[6]), 32'd4095);
        check("f7_msel",       32'(f_ms[7]), 32'd1);
        check("f7_width",      32'(f_w[7]), 32'd2);
        read_check("bank0_kept", 3'd0, 3'd0, 32'h0000_0AAA);
        read_check("bank1_pos",  3'd1, 3'd0, 32'h0001_2345);
        hang0 = 1'b0;

        // Enable dropped during motor 0: motor 1 still runs, then no new sweep.
        wait_frames(9, 3000);
        enable = 1'b0;
        wait_frames(10, 1000);
        check("f9_msel", 32'(f_ms[9]), 32'd1);
        repeat (2500) @(negedge clock);
        check("no_sweep_disabled", 32'(nframes), 32'd10);

        // Reset in WAIT_DONE clears everything at once.
        enable = 1'b1;
        wait_frames(11, 1500);
        read_motor = 3'd1;
        read_field = 3'd0;
        repeat (20) @(negedge clock);
        check("pre_rst_readdata", read_data, 32'h0001_2345);
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_rst_start",    32'(start), 32'd0);
        check("mid_rst_pwmref",   pwmRef, 32'd0);
        check("mid_rst_msel",     32'(motor_select), 32'd0);
        check("mid_rst_readdata", read_data, 32'd0);
        check("mid_rst_tflags",   32'(timeout_flags), 32'd0);
        check("mid_rst_overrun",  32'(overrun), 32'd0);
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        repeat (5) @(negedge clock);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
